uart_rx_cfg: RTL and testbench

Parametrised UART receiver and the next-generation serial input for the design.
- Frame format: data width, parity mode and stop-bit count are set by parameters.
- Noise rejection: each bit is decided by a 3-sample majority vote.
- Error detection: parity error, framing error, break and overrun are all flagged.
- Received frames are buffered in a small FIFO with a valid/ready output handshake, so a slow consumer does not lose back-to-back characters.

---
 rtl/uart_pkg.sv | 35 +++
 rtl/uart_rx_fifo.sv | 59 +++++
 rtl/uart_rx_cfg.sv | 195 +++++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the configurable UART receiver.
package uart_pkg;

  // Receiver FSM state encoding.
  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StStart    = 3'd1,
    StData     = 3'd2,
    StParity   = 3'd3,
    StStop     = 3'd4,
    StWaitIdle = 3'd5
  } state_e;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_ODD  = 1;
  localparam int unsigned PARITY_EVEN = 2;

  // FIFO entry layout: {break, frame_err, parity_err, data[DATA_BITS-1:0]}.
  function automatic int unsigned entry_width(input int unsigned data_bits);
    return data_bits + 3;
  endfunction

  function automatic int unsigned par_idx(input int unsigned data_bits);
    return data_bits;
  endfunction

  function automatic int unsigned frame_idx(input int unsigned data_bits);
    return data_bits + 1;
  endfunction

  function automatic int unsigned brk_idx(input int unsigned data_bits);
    return data_bits + 2;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous first-word-fall-through FIFO holding received frames.
module uart_rx_fifo #(
  parameter int unsigned WIDTH = 11,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           din_i,
  output logic [WIDTH-1:0]           dout_o,
  output logic                       empty_o,
  output logic                       full_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int unsigned AddrW  = $clog2(DEPTH);
  localparam int unsigned CountW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [AddrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CountW-1:0] count_q;
  logic              do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CountW'(DEPTH));
  assign count_o = count_q;
  // Head reads zero while empty so the outputs are clean after reset.
  assign dout_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  // A full FIFO still accepts a push when the head is leaving in the same cycle.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Storage array; contents need no reset because empty gates the head.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

  // Pointers wrap naturally; occupancy is tracked separately.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AddrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AddrW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CountW'(1);
        2'b01:   count_q <= count_q - CountW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_cfg.sv
// Parametrised UART receiver with majority-vote sampling, error flags and a receive FIFO.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 87,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                            i_Clock,
  input  logic                            i_Reset,
  input  logic                            i_Rx_Serial,
  input  logic                            i_Rx_Ready,
  input  logic                            i_Clear_Overrun,
  output logic                            o_Rx_DV,
  output logic [DATA_BITS-1:0]            o_Rx_Byte,
  output logic                            o_Parity_Err,
  output logic                            o_Frame_Err,
  output logic                            o_Break,
  output logic                            o_Overrun,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] o_Fifo_Count
);

  localparam int unsigned CntW     = $clog2(CLKS_PER_BIT);
  localparam int unsigned EntryW   = entry_width(DATA_BITS);
  localparam int unsigned ParIdx   = par_idx(DATA_BITS);
  localparam int unsigned FrameIdx = frame_idx(DATA_BITS);
  localparam int unsigned BrkIdx   = brk_idx(DATA_BITS);
  localparam logic [CntW-1:0] HalfCnt  = CntW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CntW-1:0] LastCnt  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]      LastData = 4'(DATA_BITS - 1);
  localparam logic [3:0]      LastStop = 4'(STOP_BITS - 1);

  logic                 sync1_q, sync2_q;
  logic [2:0]           hist_q;
  logic                 bit_value;
  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 par_bit_q, par_bit_d;
  logic                 stop_zero_q, stop_zero_d;  // some stop sample so far was 0
  logic                 stop_one_q, stop_one_d;    // some stop sample so far was 1
  logic                 overrun_q, overrun_d;
  logic                 sample_tick, mid_tick, last_stop;
  logic                 frame_err, parity_err, brk;
  logic                 push;
  logic [EntryW-1:0]    entry, head;
  logic                 fifo_empty, fifo_full, pop;

  assign bit_value   = (hist_q[0] & hist_q[1]) | (hist_q[0] & hist_q[2]) | (hist_q[1] & hist_q[2]);
  assign sample_tick = (cnt_q == LastCnt);
  assign mid_tick    = (cnt_q == HalfCnt);
  assign last_stop   = (state_q == StStop) && sample_tick && (bit_cnt_q == LastStop);

  // Two-flop synchroniser followed by a three-sample history for the majority vote.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      hist_q  <= 3'b111;
    end else begin
      sync1_q <= i_Rx_Serial;
      sync2_q <= sync1_q;
      hist_q  <= {hist_q[1:0], sync2_q};
    end
  end

  // State and frame datapath registers.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      bit_cnt_q   <= '0;
      data_q      <= '0;
      par_bit_q   <= 1'b0;
      stop_zero_q <= 1'b0;
      stop_one_q  <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      data_q      <= data_d;
      par_bit_q   <= par_bit_d;
      stop_zero_q <= stop_zero_d;
      stop_one_q  <= stop_one_d;
      overrun_q   <= overrun_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:     if (!sync2_q) state_d = StStart;
      StStart:    if (mid_tick) state_d = bit_value ? StIdle : StData;
      StData: begin
        if (sample_tick && (bit_cnt_q == LastData)) begin
          state_d = (PARITY != PARITY_NONE) ? StParity : StStop;
        end
      end
      StParity:   if (sample_tick) state_d = StStop;
      // Errored frames wait for the line to go high so a held-low line is not a new start.
      StStop:     if (last_stop) state_d = frame_err ? StWaitIdle : StIdle;
      StWaitIdle: if (sync2_q) state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  // Bit-timing counter and frame capture next-state.
  always_comb begin
    cnt_d       = cnt_q + CntW'(1);
    bit_cnt_d   = bit_cnt_q;
    data_d      = data_q;
    par_bit_d   = par_bit_q;
    stop_zero_d = stop_zero_q;
    stop_one_d  = stop_one_q;
    case (state_q)
      StIdle, StWaitIdle: begin
        cnt_d       = '0;
        bit_cnt_d   = '0;
        stop_zero_d = 1'b0;
        stop_one_d  = 1'b0;
      end
      StStart: if (mid_tick) cnt_d = '0;
      StData: begin
        if (sample_tick) begin
          cnt_d     = '0;
          data_d    = {bit_value, data_q[DATA_BITS-1:1]};
          bit_cnt_d = (bit_cnt_q == LastData) ? 4'd0 : bit_cnt_q + 4'd1;
        end
      end
      StParity: begin
        if (sample_tick) begin
          cnt_d     = '0;
          par_bit_d = bit_value;
        end
      end
      StStop: begin
        if (sample_tick) begin
          cnt_d       = '0;
          bit_cnt_d   = last_stop ? 4'd0 : bit_cnt_q + 4'd1;
          stop_zero_d = stop_zero_q | ~bit_value;
          stop_one_d  = stop_one_q | bit_value;
        end
      end
      default: cnt_d = '0;
    endcase
  end

  // Frame status at the last stop sample and the resulting FIFO push.
  always_comb begin
    brk        = (data_q == '0) && ((PARITY == PARITY_NONE) || !par_bit_q) &&
                 !(stop_one_q | bit_value);
    frame_err  = stop_zero_q | ~bit_value | brk;
    parity_err = (PARITY != PARITY_NONE) && !brk &&
                 ((^data_q ^ par_bit_q) != (PARITY == PARITY_ODD));
    push       = last_stop;
    entry      = {brk, frame_err, parity_err, data_q};
  end

  // Sticky overrun; a new drop wins over a simultaneous clear.
  always_comb begin
    overrun_d = overrun_q;
    if (i_Clear_Overrun) overrun_d = 1'b0;
    if (push && fifo_full && !pop) overrun_d = 1'b1;
  end

  assign pop = !fifo_empty && i_Rx_Ready;

  uart_rx_fifo #(
    .WIDTH (EntryW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (i_Clock),
    .rst_i   (i_Reset),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (entry),
    .dout_o  (head),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .count_o (o_Fifo_Count)
  );

  assign o_Rx_DV      = !fifo_empty;
  assign o_Rx_Byte    = head[DATA_BITS-1:0];
  assign o_Parity_Err = head[ParIdx];
  assign o_Frame_Err  = head[FrameIdx];
  assign o_Break      = head[BrkIdx];
  assign o_Overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench: an 8N1 and a 7E2 receiver driven by directed serial frames.
module tb_uart_rx_cfg;

  localparam int unsigned Cpb = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, rx8, rx7, rdy8, rdy7, clr;
  logic       dv8, pe8, fe8, brk8, ovr8;
  logic [7:0] byte8;
  logic [2:0] cnt8;
  logic       dv7, pe7, fe7, brk7, ovr7;
  logic [6:0] byte7;
  logic [2:0] cnt7;

  uart_rx_cfg #(
    .CLKS_PER_BIT (Cpb),
    .DATA_BITS    (8),
    .PARITY       (0),
    .STOP_BITS    (1),
    .FIFO_DEPTH   (4)
  ) u_dut8n1 (
    .i_Clock         (clk),
    .i_Reset         (rst),
    .i_Rx_Serial     (rx8),
    .i_Rx_Ready      (rdy8),
    .i_Clear_Overrun (clr),
    .o_Rx_DV         (dv8),
    .o_Rx_Byte       (byte8),
    .o_Parity_Err    (pe8),
    .o_Frame_Err     (fe8),
    .o_Break         (brk8),
    .o_Overrun       (ovr8),
    .o_Fifo_Count    (cnt8)
  );

  uart_rx_cfg #(
    .CLKS_PER_BIT (Cpb),
    .DATA_BITS    (7),
    .PARITY       (2),
    .STOP_BITS    (2),
    .FIFO_DEPTH   (4)
  ) u_dut7e2 (
    .i_Clock         (clk),
    .i_Reset         (rst),
    .i_Rx_Serial     (rx7),
    .i_Rx_Ready      (rdy7),
    .i_Clear_Overrun (clr),
    .o_Rx_DV         (dv7),
    .o_Rx_Byte       (byte7),
    .o_Parity_Err    (pe7),
    .o_Frame_Err     (fe7),
    .o_Break         (brk7),
    .o_Overrun       (ovr7),
    .o_Fifo_Count    (cnt7)
  );

  typedef struct packed {
    logic [8:0] data;
    logic       pe;
    logic       fe;
    logic       brk;
  } exp_t;

  exp_t q8[$];
  exp_t q7[$];
  int   total = 0;
  int   bad   = 0;

  function automatic exp_t mk(input logic [8:0] d, input logic pe, input logic fe, input logic b);
    exp_t e;
    e.data = d;
    e.pe   = pe;
    e.fe   = fe;
    e.brk  = b;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic set_line(input bit sel, input logic v);
    if (sel) rx7 = v;
    else     rx8 = v;
  endtask

  // Drives one frame starting at a falling clock edge; glitch_bit >= 0 inverts one
  // cycle at the middle of that data bit.
  task automatic send(input bit sel, input logic [8:0] data, input int nbits,
                      input int par_mode, input bit flip_par, input int nstop,
                      input int glitch_bit);
    logic [15:0] bits;
    logic        p;
    int          n;
    bits    = '1;
    bits[0] = 1'b0;
    n       = 1;
    p       = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      bits[n] = data[i];
      p       = p ^ data[i];
      n++;
    end
    if (par_mode != 0) begin
      if (par_mode == 1) p = ~p;
      bits[n] = p ^ flip_par;
      n++;
    end
    n = n + nstop;
    for (int i = 0; i < n; i++) begin
      set_line(sel, bits[i]);
      if ((glitch_bit >= 0) && (i == glitch_bit + 1)) begin
        repeat (Cpb / 2) @(negedge clk);
        set_line(sel, ~bits[i]);
        @(negedge clk);
        set_line(sel, bits[i]);
        repeat (Cpb / 2 - 1) @(negedge clk);
      end else begin
        repeat (Cpb) @(negedge clk);
      end
    end
  endtask

  // Monitor: every accepted head entry is compared with the oldest expectation.
  initial begin : monitor
    exp_t e8, e7;
    forever begin
      @(negedge clk);
      #1;
      if (dv8 && rdy8) begin
        if (q8.size() == 0) begin
          total++;
          bad++;
          $display("FAIL entry8_unexpected: got data %0h, required no entry", byte8);
        end else begin
          e8 = q8.pop_front();
          check("entry8", {1'b0, byte8, pe8, fe8, brk8}, e8);
        end
      end
      if (dv7 && rdy7) begin
        if (q7.size() == 0) begin
          total++;
          bad++;
          $display("FAIL entry7_unexpected: got data %0h, required no entry", byte7);
        end else begin
          e7 = q7.pop_front();
          check("entry7", {2'b0, byte7, pe7, fe7, brk7}, e7);
        end
      end
    end
  end

  initial begin : stim
    int cyc;
    rst  = 1'b1;
    rx8  = 1'b1;
    rx7  = 1'b1;
    rdy8 = 1'b1;
    rdy7 = 1'b1;
    clr  = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    check("rst_dv8", dv8, 0);
    check("rst_cnt8", cnt8, 0);
    check("rst_ovr8", ovr8, 0);
    check("rst_head8", {byte8, pe8, fe8, brk8}, 0);
    check("rst_dv7", dv7, 0);
    check("rst_cnt7", cnt7, 0);

    // 8N1 0xA5: start edge at N0 reaches sync2 after 2 edges, START after 3, mid-start
    // check at edge 11, bit k sampled at edge 27+16k, stop (k=8) at edge 155 -> DV at 155.
    q8.push_back(mk(9'h0A5, 0, 0, 0));
    @(negedge clk);
    fork
      send(0, 9'h0A5, 8, 0, 0, 1, -1);
      begin
        cyc = 0;
        while (!dv8 && cyc < 400) begin
          @(negedge clk);
          #1;
          cyc++;
        end
      end
    join
    check("dv_latency", cyc, 155);
    repeat (20) @(negedge clk);
    check("t1_cnt8", cnt8, 0);

    // 7E2: 0x41 has two ones, even parity bit 0; the flipped frame is a parity error.
    q7.push_back(mk(9'h041, 0, 0, 0));
    q7.push_back(mk(9'h041, 1, 0, 0));
    send(1, 9'h041, 7, 2, 0, 2, -1);
    send(1, 9'h041, 7, 2, 1, 2, -1);
    repeat (20) @(negedge clk);
    check("t2_cnt7", cnt7, 0);

    // Overrun: five back-to-back frames into a 4-deep FIFO with no consumer.
    rdy8 = 1'b0;
    for (int b = 1; b <= 4; b++) q8.push_back(mk(9'(b), 0, 0, 0));
    for (int b = 1; b <= 5; b++) send(0, 9'(b), 8, 0, 0, 1, -1);
    repeat (20) @(negedge clk);
    #1;
    check("t3_cnt_full", cnt8, 4);
    check("t3_ovr_set", ovr8, 1);
    check("t3_dv_held", dv8, 1);
    check("t3_head_stable", byte8, 8'h01);
    @(negedge clk);
    rdy8 = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    check("t3_cnt_drained", cnt8, 0);
    check("t3_ovr_sticky", ovr8, 1);
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    #1;
    check("t3_ovr_cleared", ovr8, 0);

    // Break: line low for 12 bit times, then a normal frame after release.
    q8.push_back(mk(9'h000, 0, 1, 1));
    @(negedge clk);
    set_line(0, 1'b0);
    repeat (12 * Cpb) @(negedge clk);
    set_line(0, 1'b1);
    repeat (40) @(negedge clk);
    #1;
    check("t4_cnt_after_break", cnt8, 0);
    q8.push_back(mk(9'h05A, 0, 0, 0));
    @(negedge clk);
    send(0, 9'h05A, 8, 0, 0, 1, -1);
    repeat (20) @(negedge clk);

    // Single-cycle low glitch on an idle line must not create an entry.
    rdy8 = 1'b0;
    set_line(0, 1'b0);
    @(negedge clk);
    set_line(0, 1'b1);
    repeat (3 * Cpb) @(negedge clk);
    #1;
    check("t5_glitch_cnt", cnt8, 0);
    check("t5_glitch_dv", dv8, 0);
    @(negedge clk);
    rdy8 = 1'b1;

    // One-cycle inverted pulse at mid data bit 3 of 0x00 is outvoted.
    q8.push_back(mk(9'h000, 0, 0, 0));
    send(0, 9'h000, 8, 0, 0, 1, 3);
    repeat (20) @(negedge clk);

    // Reset in the middle of data bit 4 of 0xF0 (rest of the frame is high), then 0x3C.
    rdy8 = 1'b0;
    fork
      send(0, 9'h0F0, 8, 0, 0, 1, -1);
      begin
        repeat (5 * Cpb + Cpb / 2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
    join
    repeat (10) @(negedge clk);
    q8.push_back(mk(9'h03C, 0, 0, 0));
    send(0, 9'h03C, 8, 0, 0, 1, -1);
    repeat (20) @(negedge clk);
    #1;
    check("t6_cnt", cnt8, 1);
    check("t6_ovr", ovr8, 0);
    check("t6_head", byte8, 8'h3C);
    @(negedge clk);
    rdy8 = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    check("t6_cnt_drained", cnt8, 0);

    check("q8_empty", q8.size(), 0);
    check("q7_empty", q7.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
